// File: rtl/wb_arbiter.sv
// Two-requester writeback arbiter feeding a single registered register-file port.
// Optional per-requester grant counters are enabled with `define WB_ARB_STATS_EN.
module wb_arbiter #(
   parameter int DATA_W = 64,
   parameter int RD_W   = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        req_valid,
   input  logic [DATA_W-1:0] req_data0,
   input  logic [DATA_W-1:0] req_data1,
   input  logic [RD_W-1:0]   req_rd0,
   input  logic [RD_W-1:0]   req_rd1,
   output logic [1:0]        req_ready,
   output logic              wb_valid,
   output logic [DATA_W-1:0] wb_data,
   output logic [RD_W-1:0]   wb_rd,
   output logic              wb_src,
   input  logic              wb_ready
`ifdef WB_ARB_STATS_EN
   ,
   output logic [15:0]       grant_cnt0,
   output logic [15:0]       grant_cnt1
`endif
);

   // Handshake: a beat moves on any cycle where valid and ready are both high;
   // sources hold valid/data/rd stable until that cycle.
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t              state;
   logic                last_grant;
   logic                has_win;
   logic                win;
   logic                can_accept;
   logic                accept;
   logic                fwd;
   logic [RD_W-1:0]     win_rd;
   logic [DATA_W-1:0]   win_data;

   assign wb_valid = (state == FULL);

   always_comb begin
      has_win    = |req_valid;
      win        = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
      // rst_n gating keeps req_ready low for the whole reset window
      can_accept = rst_n && ((state == EMPTY) || wb_ready);
      accept     = has_win && can_accept;
      win_rd     = win ? req_rd1 : req_rd0;
      win_data   = win ? req_data1 : req_data0;
      fwd        = accept && (win_rd != '0);
      req_ready  = 2'b00;
      if (accept) req_ready[win] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= EMPTY;
         last_grant <= 1'b1;
         wb_data    <= '0;
         wb_rd      <= '0;
         wb_src     <= 1'b0;
      end else begin
         if (accept) last_grant <= win;
         // writes to r0 are consumed but never reach the register file
         if (fwd) begin
            state   <= FULL;
            wb_data <= win_data;
            wb_rd   <= win_rd;
            wb_src  <= win;
         end else if ((state == FULL) && wb_ready) begin
            state <= EMPTY;
         end
      end
   end

`ifdef WB_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else if (fwd) begin
         if (!win && (grant_cnt0 != 16'hFFFF)) grant_cnt0 <= grant_cnt0 + 16'd1;
         if (win && (grant_cnt1 != 16'hFFFF))  grant_cnt1 <= grant_cnt1 + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a cycle model predicts req_ready and pushes
// forwarded beats to exp_q; beats are compared while held and popped on drain.
module tb_wb_arbiter;

   localparam int DATA_W = 64;
   localparam int RD_W   = 5;
   localparam int W      = 1 + RD_W + DATA_W;

   logic              clk;
   logic              rst_n;
   logic [1:0]        req_valid;
   logic [DATA_W-1:0] req_data0, req_data1;
   logic [RD_W-1:0]   req_rd0, req_rd1;
   logic [1:0]        req_ready;
   logic              wb_valid;
   logic [DATA_W-1:0] wb_data;
   logic [RD_W-1:0]   wb_rd;
   logic              wb_src;
   logic              wb_ready;
`ifdef WB_ARB_STATS_EN
   logic [15:0]       grant_cnt0, grant_cnt1;
`endif

   wb_arbiter #(.DATA_W(DATA_W), .RD_W(RD_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data0 (req_data0),
      .req_data1 (req_data1),
      .req_rd0   (req_rd0),
      .req_rd1   (req_rd1),
      .req_ready (req_ready),
      .wb_valid  (wb_valid),
      .wb_data   (wb_data),
      .wb_rd     (wb_rd),
      .wb_src    (wb_src),
      .wb_ready  (wb_ready)
`ifdef WB_ARB_STATS_EN
      ,
      .grant_cnt0 (grant_cnt0),
      .grant_cnt1 (grant_cnt1)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   logic [W-1:0]      exp_q[$];
   logic [W-1:0]      m_last;
   logic              m_full;
   logic              m_lg;
   int unsigned       m_cnt0, m_cnt1;

   logic [DATA_W-1:0] cur_d0, cur_d1;
   logic [RD_W-1:0]   cur_r0, cur_r1;
   int unsigned       rd_min;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic regen(input logic w);
      if (w) begin
         cur_d1 = {$urandom(), $urandom()};
         cur_r1 = RD_W'($urandom_range(31, rd_min));
      end else begin
         cur_d0 = {$urandom(), $urandom()};
         cur_r0 = RD_W'($urandom_range(31, rd_min));
      end
   endtask

   // drives one cycle at the falling edge, checks, then advances the model
   task automatic step(input logic [1:0] v, input logic wr);
      logic            ca, hw, w;
      logic [1:0]      er;
      logic [RD_W-1:0] wrd;
      @(negedge clk);
      req_valid = v;
      wb_ready  = wr;
      req_data0 = cur_d0;
      req_data1 = cur_d1;
      req_rd0   = cur_r0;
      req_rd1   = cur_r1;
      #1;
      hw = |v;
      w  = (v == 2'b11) ? ~m_lg : v[1];
      ca = !m_full || wr;
      er = (hw && ca) ? (w ? 2'b10 : 2'b01) : 2'b00;
      check("req_ready", W'(req_ready), W'(er));
      check("wb_valid", W'(wb_valid), W'(m_full));
      if (m_full) begin
         if (exp_q.size() == 0) check("sb_underflow", W'(exp_q.size()), W'(1));
         else begin
            check("wb_beat", {wb_src, wb_rd, wb_data}, exp_q[0]);
            if (wr) m_last = exp_q.pop_front();
         end
      end else begin
         check("wb_idle_hold", {wb_src, wb_rd, wb_data}, m_last);
      end
      if (hw && ca) begin
         m_lg = w;
         wrd  = w ? cur_r1 : cur_r0;
         if (wrd != '0) begin
            exp_q.push_back({w, wrd, w ? cur_d1 : cur_d0});
            m_full = 1'b1;
            if (w) m_cnt1 = (m_cnt1 == 65535) ? m_cnt1 : m_cnt1 + 1;
            else   m_cnt0 = (m_cnt0 == 65535) ? m_cnt0 : m_cnt0 + 1;
         end else if (m_full && wr) begin
            m_full = 1'b0;
         end
         regen(w);
      end else if (m_full && wr) begin
         m_full = 1'b0;
      end
   endtask

   task automatic check_stats(input string tag);
`ifdef WB_ARB_STATS_EN
      check({tag, "_cnt0"}, W'(grant_cnt0), W'(m_cnt0));
      check({tag, "_cnt1"}, W'(grant_cnt1), W'(m_cnt1));
`else
      check({tag, "_valid"}, W'(wb_valid), W'(m_full));
`endif
   endtask

   // asserts reset away from any clock edge and releases it mid-cycle
   task automatic do_reset();
      #2;
      rst_n     = 1'b0;
      req_valid = 2'b11;
      wb_ready  = 1'b1;
      #1;
      check("rst_valid", W'(wb_valid), W'(0));
      check("rst_ready", W'(req_ready), W'(0));
      check("rst_beat", {wb_src, wb_rd, wb_data}, W'(0));
      exp_q.delete();
      m_full = 1'b0;
      m_lg   = 1'b1;
      m_last = '0;
      m_cnt0 = 0;
      m_cnt1 = 0;
      check_stats("rst");
      @(negedge clk);
      @(negedge clk);
      req_valid = 2'b00;
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b1;
      req_valid = 2'b00;
      wb_ready  = 1'b0;
      rd_min    = 1;
      cur_d0 = '0; cur_d1 = '0; cur_r0 = '0; cur_r1 = '0;
      req_data0 = '0; req_data1 = '0; req_rd0 = '0; req_rd1 = '0;
      m_full = 1'b0; m_lg = 1'b1; m_last = '0; m_cnt0 = 0; m_cnt1 = 0;
      do_reset();

      // single ALU request: accept, beat visible next cycle, then drain
      cur_d0 = 64'hA5A5;
      cur_r0 = 5'd3;
      step(2'b01, 1'b1);
      step(2'b00, 1'b1);
      step(2'b00, 1'b1);

      // continuous tie with sink ready: grants alternate, no bubbles
      regen(1'b0); regen(1'b1);
      repeat (6) step(2'b11, 1'b1);
      step(2'b00, 1'b1);

      // stall while full: outputs held, nothing accepted
      step(2'b11, 1'b1);
      repeat (4) step(2'b11, 1'b0);
      step(2'b11, 1'b1);
      step(2'b00, 1'b1);
      step(2'b00, 1'b1);

      // write to r0 on load path is consumed and dropped; next tie goes to ALU
      cur_r1 = '0;
      step(2'b10, 1'b1);
      step(2'b00, 1'b1);
      cur_r0 = 5'd7;
      cur_r1 = 5'd9;
      step(2'b11, 1'b1);
      step(2'b00, 1'b1);

      // random traffic including r0 drops and sink stalls
      rd_min = 0;
      regen(1'b0); regen(1'b1);
      repeat (300) step(2'($urandom_range(3, 0)), ($urandom_range(3, 0) != 0));
      check_stats("rand");

      // reset pulse while a beat is held
      rd_min = 1;
      regen(1'b0);
      step(2'b01, 1'b0);
      @(posedge clk);
      #1;
      check("pre_rst_valid", W'(wb_valid), W'(m_full));
      do_reset();
      repeat (3) step(2'b00, 1'b1);

`ifdef WB_ARB_STATS_EN
      // saturation of the ALU-path counter
      repeat (70000) step(2'b01, 1'b1);
      step(2'b00, 1'b1);
      check("sat_cnt0", W'(grant_cnt0), W'(16'hFFFF));
      check_stats("sat");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
